// File: rtl/uart_cmd_resp_if.sv
// rtl/uart_cmd_resp_if.sv - uart byte and flash req/ack bundle for uart_cmd_resp
//
// Groups the uart receive/transmit handshake and the flash access bus.
//   master : responder view (uart_cmd_resp drives tx_trig, data_tx, mem_*, err)
//   slave  : environment view (uart top / flash controller / test bench)
// Signals:
//   rx_flag, data_rx      received-byte flag and byte from the uart
//   busy                  uart transmitter busy
//   tx_trig, data_tx      transmit request and byte to the uart
//   mem_req, mem_we       flash access request, 1 = write
//   mem_addr, mem_wdata   24-bit byte address, write data
//   mem_ack, mem_rdata    one-cycle completion strobe, read data
//   err                   one-cycle error-response pulse
interface uart_cmd_resp_if;
  logic        rx_flag;
  logic [7:0]  data_rx;
  logic        busy;
  logic        tx_trig;
  logic [7:0]  data_tx;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err;

  modport master (
    input  rx_flag, data_rx, busy, mem_ack, mem_rdata,
    output tx_trig, data_tx, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    output rx_flag, data_rx, busy, mem_ack, mem_rdata,
    input  tx_trig, data_tx, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/uart_cmd_resp.sv
// rtl/uart_cmd_resp.sv - uart command parser and 3-byte responder for flash byte access
//
// Parses HDR_CMD, CMD, A2, A1, A0, [DATA], CHK frames from the uart receiver,
// performs one flash byte read/write over a req/ack bus, and answers with
// HDR_RSP, STATUS, DATA through the uart transmitter handshake.
// Optional build macro UART_CMD_TIMEOUT_EN: abandon a partial frame after
// TIMEOUT_CYC clk of inter-byte silence.
// Ports:
//   clk    system clock (shared with the uart top)
//   rst_n  asynchronous active-low reset
//   bus    uart_cmd_resp_if.master (uart byte handshake + flash req/ack)
module uart_cmd_resp #(
  parameter int         TIMEOUT_CYC = 5000000,
  parameter logic [7:0] HDR_CMD     = 8'hA5,
  parameter logic [7:0] HDR_RSP     = 8'h5A
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_resp_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CMD      = 4'd1;
  localparam logic [3:0] S_A2       = 4'd2;
  localparam logic [3:0] S_A1       = 4'd3;
  localparam logic [3:0] S_A0       = 4'd4;
  localparam logic [3:0] S_DATA     = 4'd5;
  localparam logic [3:0] S_CHK      = 4'd6;
  localparam logic [3:0] S_MEM      = 4'd7;
  localparam logic [3:0] S_RSP_LOAD = 4'd8;
  localparam logic [3:0] S_RSP_TRIG = 4'd9;
  localparam logic [3:0] S_RSP_WAIT = 4'd10;

  localparam logic [7:0] CMD_RD  = 8'h01;
  localparam logic [7:0] CMD_WR  = 8'h02;
  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_CHK  = 8'hE1;
  localparam logic [7:0] ST_BCMD = 8'hE2;

  logic [2:0]  rx_sync;   // [1:0] synchroniser, [2] previous value for edge detect
  logic        byte_vld;
  logic [7:0]  byte_q;
  logic [3:0]  state;
  logic [7:0]  cmd_q;
  logic [23:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  chk_q;
  logic [7:0]  status_q;
  logic [7:0]  rdata_q;
  logic [1:0]  rsp_idx;
  logic        tx_trig_q;
  logic [7:0]  data_tx_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        err_q;
  logic        to_hit;
  logic [7:0]  rsp_byte;
  logic        cmd_ok;

  assign cmd_ok = (cmd_q == CMD_RD) || (cmd_q == CMD_WR);

  // Byte strobe: one clk after the synchronised rising edge of rx_flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 3'b000;
      byte_vld <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      rx_sync  <= {rx_sync[1:0], bus.rx_flag};
      byte_vld <= rx_sync[1] & ~rx_sync[2];
      if (rx_sync[1] & ~rx_sync[2]) byte_q <= bus.data_rx;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] to_cnt;
  logic        in_frame;

  assign in_frame = (state >= S_CMD) && (state <= S_CHK);
  // A byte strobe in the same cycle wins over the timeout.
  assign to_hit   = in_frame && !byte_vld && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            to_cnt <= 32'd0;
    else if (!in_frame || byte_vld || to_hit) to_cnt <= 32'd0;
    else                                   to_cnt <= to_cnt + 32'd1;
  end
`else
  // Timeout compiled out: partial frames wait indefinitely; TIMEOUT_CYC has no effect.
  assign to_hit = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    rsp_byte = 8'h00;
    case (rsp_idx)
      2'd0:    rsp_byte = HDR_RSP;
      2'd1:    rsp_byte = status_q;
      2'd2:    rsp_byte = rdata_q;
      default: rsp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_q     <= 8'h00;
      addr_q    <= 24'h000000;
      wdata_q   <= 8'h00;
      chk_q     <= 8'h00;
      status_q  <= 8'h00;
      rdata_q   <= 8'h00;
      rsp_idx   <= 2'd0;
      tx_trig_q <= 1'b0;
      data_tx_q <= 8'h00;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (to_hit) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (byte_vld && byte_q == HDR_CMD) begin
            state    <= S_CMD;
            chk_q    <= 8'h00;
            rdata_q  <= 8'h00;   // DATA byte is 0 unless a read completes
            status_q <= ST_OK;
            rsp_idx  <= 2'd0;
          end
          S_CMD: if (byte_vld) begin
            cmd_q <= byte_q;
            chk_q <= byte_q;
            state <= S_A2;
          end
          S_A2: if (byte_vld) begin
            addr_q[23:16] <= byte_q;
            chk_q         <= chk_q ^ byte_q;
            state         <= S_A1;
          end
          S_A1: if (byte_vld) begin
            addr_q[15:8] <= byte_q;
            chk_q        <= chk_q ^ byte_q;
            state        <= S_A0;
          end
          S_A0: if (byte_vld) begin
            addr_q[7:0] <= byte_q;
            chk_q       <= chk_q ^ byte_q;
            state       <= (cmd_q == CMD_WR) ? S_DATA : S_CHK;
          end
          S_DATA: if (byte_vld) begin
            wdata_q <= byte_q;
            chk_q   <= chk_q ^ byte_q;
            state   <= S_CHK;
          end
          S_CHK: if (byte_vld) begin
            if (byte_q != chk_q) begin
              status_q <= ST_CHK;
              err_q    <= 1'b1;
              state    <= S_RSP_LOAD;
            end else if (!cmd_ok) begin
              status_q <= ST_BCMD;
              err_q    <= 1'b1;
              state    <= S_RSP_LOAD;
            end else begin
              mem_req_q <= 1'b1;
              mem_we_q  <= (cmd_q == CMD_WR);
              state     <= S_MEM;
            end
          end
          S_MEM: if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) rdata_q <= bus.mem_rdata;
            status_q  <= ST_OK;
            state     <= S_RSP_LOAD;
          end
          // tx_trig is raised together with the load so it is high in RSP_TRIG.
          S_RSP_LOAD: if (!bus.busy) begin
            data_tx_q <= rsp_byte;
            tx_trig_q <= 1'b1;
            state     <= S_RSP_TRIG;
          end
          S_RSP_TRIG: if (bus.busy) begin
            tx_trig_q <= 1'b0;
            state     <= S_RSP_WAIT;
          end
          S_RSP_WAIT: if (!bus.busy) begin
            if (rsp_idx == 2'd2) begin
              state <= S_IDLE;
            end else begin
              rsp_idx <= rsp_idx + 2'd1;
              state   <= S_RSP_LOAD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_trig   = tx_trig_q;
  assign bus.data_tx   = data_tx_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err       = err_q;

endmodule
